stride_prefetcher: RTL and testbench
====================================

# stride_prefetcher

- Data-side stride prefetcher that sits directly upstream of the two-way data cache.
- Trains a PC-indexed reference prediction table (RPT) on every data load and queues stride-predicted block addresses.
- Issues those addresses to the memory load port in cycles when no demand load is presented.
- Keeps an outstanding-request list (ORL) that tells the cache which address the memory's current return belongs to.

## Interface

Parameters:
- RPT_ENTRIES, 16: RPT entries, direct-mapped; index pc[3:0], tag pc[15:4].
- PQ_DEPTH, 2: prefetch queue depth.
- MEM_LATENCY, 4: cycles from memory load-port request to returned data. Equals the memory load-port latency.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  16  PC of the load presented this cycle.
- dReadEnable  in  1  demand load presented this cycle.
- dAddress  in  16  demand load address.
- memIssue  in  1  memory load port accepted a request this cycle (demand miss or prefetch).
- memIssueAddr  in  16  address of that request.
- memRequest  out  1  prefetch request to the memory load port.
- requestAddress  out  16  prefetch address; the queue head.
- orlOutput  out  16  address whose data memory returns this cycle; 16'hFFFF when none.
- orlValid  out  1  orlOutput holds a real address.

## Operation

RPT entry fields: valid, tag[11:0], prev[15:0], stride[15:0], state[1:0]. States are INIT, TRANSIENT, STEADY, NOPRED.

On a clock edge with dReadEnable=1, look up the entry at pc[3:0]:
- **Miss** (invalid entry or tag mismatch): allocate with tag, prev=dAddress, stride=0, state=INIT. No prefetch.
- **Hit**: compute correct = ((dAddress − prev) mod 2^16 == stride). Transitions:
  - INIT: correct→STEADY; else→TRANSIENT, stride=new.
  - TRANSIENT: correct→STEADY; else→NOPRED, stride=new.
  - STEADY: correct→STEADY; else→INIT, stride unchanged.
  - NOPRED: correct→TRANSIENT; else→NOPRED, stride=new.
  - In every case prev=dAddress.
- **Prefetch candidate**: if the next state is STEADY and stride≠0, the candidate is (dAddress + stride) mod 2^16.

Duplicate filter. The candidate is dropped if its block (addr[15:2]) matches any of:
- dAddress[15:2];
- any valid queue entry;
- any valid ORL stage;
- memIssueAddr[15:2] when memIssue=1.

Prefetch queue (FIFO, PQ_DEPTH entries):
- Push: a surviving candidate.
- Pop: when memRequest=1.
- Full and no pop in the same cycle: the candidate is dropped.
- Simultaneous push and pop on a full queue is allowed; pop happens first.

Request outputs:
- memRequest = queue non-empty && !dReadEnable. Combinational, so a demand load always wins.
- requestAddress = queue head, or 16'h0000 when empty.

ORL:
- MEM_LATENCY-stage shift register of {valid, addr}.
- Each edge shifts in {memIssue, memIssueAddr}.
- orlValid and orlOutput come from the last stage; orlOutput=16'hFFFF when that stage is invalid.

## Timing

- Reset clears all RPT valid bits, the queue and the ORL valid bits.
- Output values during and immediately after reset: memRequest=0, requestAddress=0, orlValid=0, orlOutput=16'hFFFF.
- Reset asserted mid-operation discards any queued prefetches and all in-flight ORL tracking.
- Training latency: the load at edge t updates the RPT and queue at edge t. The earliest memRequest is in cycle t+1.
- The queue head stays stable while memRequest is blocked by dReadEnable.
- ORL: an issue sampled at edge t appears on orlOutput during cycle t+MEM_LATENCY, for exactly one cycle.
- Back-to-back issues appear on back-to-back cycles.
- Address and stride arithmetic is 16-bit modulo: 0xFFFC + 4 = 0x0000.
- A negative stride is its two's-complement value.

## Test plan

1. **Reset**: hold reset 2 cycles with random inputs → memRequest=0, requestAddress=0, orlValid=0, orlOutput=FFFF.
2. **Stride training**: pc=0x0010 loads 0x0100, 0x0104, 0x0108 on consecutive dReadEnable cycles, then dReadEnable=0 → memRequest=1 with requestAddress=0x010C in the cycle after the third load; queue empties after one cycle.
3. **Demand priority**: repeat scenario 2, then hold dReadEnable=1 with unrelated pcs/addresses for 3 cycles → memRequest=0 throughout and requestAddress stays 0x010C; memRequest=1 in the first cycle dReadEnable=0.
4. **ORL timing**: memIssue=1 with addr 0x0200 at cycle 5, memIssue=0 otherwise → orlValid=1 and orlOutput=0x0200 in cycle 9 only; FFFF in all other cycles.
5. **Aliasing**: train pc=0x0010 to STEADY, then a load from pc=0x0020 (same index, different tag) → entry reallocated as INIT, no prefetch; the next pc=0x0010 load reallocates again.
6. **Filter and overflow**: train a stride-4 stream while dReadEnable stays high so the queue fills (2 entries), then a third candidate arrives → third candidate dropped. Separately, a candidate whose block matches a valid ORL stage → not queued. Wrap case: pc=0x0030 loads 0xFFF4, 0xFFF8, 0xFFFC → prefetch 0x0000.

Source files
------------

// File: rtl/stride_prefetcher_if.sv
// Load-side bus between the core/cache and the stride prefetcher.
// The master drives load/issue traffic; the slave (prefetcher) returns requests and ORL tags.
interface stride_prefetcher_if;
  logic [15:0] pc;
  logic        dReadEnable;
  logic [15:0] dAddress;
  logic        memIssue;
  logic [15:0] memIssueAddr;
  logic        memRequest;
  logic [15:0] requestAddress;
  logic [15:0] orlOutput;
  logic        orlValid;

  modport master (
    output pc, dReadEnable, dAddress, memIssue, memIssueAddr,
    input  memRequest, requestAddress, orlOutput, orlValid
  );

  modport slave (
    input  pc, dReadEnable, dAddress, memIssue, memIssueAddr,
    output memRequest, requestAddress, orlOutput, orlValid
  );
endinterface

// File: rtl/stride_prefetcher.sv
// PC-indexed stride prefetcher: trains an RPT on demand loads, queues predicted blocks,
// issues them when the load port is idle, and tracks in-flight memory returns (ORL).
module stride_prefetcher #(
  parameter int unsigned RPT_ENTRIES = 16,
  parameter int unsigned PQ_DEPTH    = 2,
  parameter int unsigned MEM_LATENCY = 4
) (
  input logic               clk,
  input logic               reset,
  stride_prefetcher_if.slave io
);
  localparam int unsigned AW      = 16;
  localparam int unsigned IDX_W   = $clog2(RPT_ENTRIES);
  localparam int unsigned TAG_W   = AW - IDX_W;
  localparam int unsigned CNT_W   = $clog2(PQ_DEPTH + 1);
  localparam int unsigned BLK_LSB = 2;
  localparam int unsigned BLK_W   = AW - BLK_LSB;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_TRANSIENT = 2'd1,
    ST_STEADY    = 2'd2,
    ST_NOPRED    = 2'd3
  } rpt_state_e;

  function automatic logic [BLK_W-1:0] blk(input logic [AW-1:0] a);
    return a[AW-1:BLK_LSB];
  endfunction

  logic [RPT_ENTRIES-1:0] rpt_valid_q;
  logic [TAG_W-1:0]       rpt_tag_q    [RPT_ENTRIES];
  logic [AW-1:0]          rpt_prev_q   [RPT_ENTRIES];
  logic [AW-1:0]          rpt_stride_q [RPT_ENTRIES];
  rpt_state_e             rpt_state_q  [RPT_ENTRIES];

  logic [AW-1:0]    pq_addr_q [PQ_DEPTH];
  logic [AW-1:0]    pq_addr_d [PQ_DEPTH];
  logic [CNT_W-1:0] pq_cnt_q, pq_cnt_d;

  logic [MEM_LATENCY-1:0] orl_vld_q, orl_vld_d;
  logic [AW-1:0]          orl_addr_q [MEM_LATENCY];
  logic [AW-1:0]          orl_addr_d [MEM_LATENCY];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit, correct, cand_valid, dup, pop, push, mem_req, orl_valid;
  logic [AW-1:0]    delta, stride_d, cand_addr;
  rpt_state_e       state_d;

  // RPT lookup and stride-confidence state transition for the presented load.
  always_comb begin
    idx      = io.pc[IDX_W-1:0];
    tag      = io.pc[AW-1:IDX_W];
    hit      = rpt_valid_q[idx] && (rpt_tag_q[idx] == tag);
    delta    = io.dAddress - rpt_prev_q[idx];
    correct  = (delta == rpt_stride_q[idx]);
    state_d  = ST_INIT;
    stride_d = '0;
    if (hit) begin
      stride_d = rpt_stride_q[idx];
      unique case (rpt_state_q[idx])
        ST_INIT: begin
          if (correct) state_d = ST_STEADY;
          else begin
            state_d  = ST_TRANSIENT;
            stride_d = delta;
          end
        end
        ST_TRANSIENT: begin
          if (correct) state_d = ST_STEADY;
          else begin
            state_d  = ST_NOPRED;
            stride_d = delta;
          end
        end
        ST_STEADY: begin
          state_d = correct ? ST_STEADY : ST_INIT;
        end
        ST_NOPRED: begin
          if (correct) state_d = ST_TRANSIENT;
          else begin
            state_d  = ST_NOPRED;
            stride_d = delta;
          end
        end
      endcase
    end
    cand_addr  = io.dAddress + stride_d;
    cand_valid = io.dReadEnable && hit && (state_d == ST_STEADY) && (stride_d != '0);
  end

  // Drop candidates whose block is already demanded, queued, issuing or in flight.
  always_comb begin
    dup = (blk(cand_addr) == blk(io.dAddress)) ||
          (io.memIssue && (blk(cand_addr) == blk(io.memIssueAddr)));
    for (int unsigned i = 0; i < PQ_DEPTH; i++) begin
      if ((CNT_W'(i) < pq_cnt_q) && (blk(pq_addr_q[i]) == blk(cand_addr))) dup = 1'b1;
    end
    for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
      if (orl_vld_q[i] && (blk(orl_addr_q[i]) == blk(cand_addr))) dup = 1'b1;
    end
  end

  assign mem_req = !reset && (pq_cnt_q != '0) && !io.dReadEnable;
  assign pop     = mem_req;

  // Shift-style FIFO: pop first so a full queue can still accept this cycle's candidate.
  always_comb begin
    pq_addr_d = pq_addr_q;
    pq_cnt_d  = pq_cnt_q;
    if (pop) begin
      for (int unsigned i = 0; i + 1 < PQ_DEPTH; i++) pq_addr_d[i] = pq_addr_q[i + 1];
      pq_cnt_d = pq_cnt_q - CNT_W'(1);
    end
    push = cand_valid && !dup && (pq_cnt_d < CNT_W'(PQ_DEPTH));
    if (push) begin
      for (int unsigned i = 0; i < PQ_DEPTH; i++) begin
        if (CNT_W'(i) == pq_cnt_d) pq_addr_d[i] = cand_addr;
      end
      pq_cnt_d = pq_cnt_d + CNT_W'(1);
    end
  end

  always_comb begin
    orl_vld_d[0]  = io.memIssue;
    orl_addr_d[0] = io.memIssueAddr;
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      orl_vld_d[i]  = orl_vld_q[i - 1];
      orl_addr_d[i] = orl_addr_q[i - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_valid_q <= '0;
      pq_cnt_q    <= '0;
      orl_vld_q   <= '0;
    end else begin
      if (io.dReadEnable) rpt_valid_q[idx] <= 1'b1;
      pq_cnt_q  <= pq_cnt_d;
      orl_vld_q <= orl_vld_d;
    end
  end

  // Payload storage; qualified by the valid bits / count above.
  always_ff @(posedge clk) begin
    if (io.dReadEnable) begin
      rpt_tag_q[idx]    <= tag;
      rpt_prev_q[idx]   <= io.dAddress;
      rpt_stride_q[idx] <= stride_d;
      rpt_state_q[idx]  <= state_d;
    end
    pq_addr_q  <= pq_addr_d;
    orl_addr_q <= orl_addr_d;
  end

  assign orl_valid         = !reset && orl_vld_q[MEM_LATENCY-1];
  assign io.memRequest     = mem_req;
  assign io.requestAddress = (reset || (pq_cnt_q == '0)) ? '0 : pq_addr_q[0];
  assign io.orlValid       = orl_valid;
  assign io.orlOutput      = orl_valid ? orl_addr_q[MEM_LATENCY-1] : 16'hFFFF;
endmodule

// File: tb/tb_stride_prefetcher.sv
// Directed bench for stride_prefetcher with prefetch and ORL scoreboards.
module tb_stride_prefetcher;
  logic clk;
  logic reset;

  stride_prefetcher_if bus();

  stride_prefetcher #(.RPT_ENTRIES(16), .PQ_DEPTH(2), .MEM_LATENCY(4)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } orl_exp_t;

  logic [15:0] pf_q[$];
  orl_exp_t    orl_q[$];
  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are checked mid-cycle, expectations queued for later edges.
  task automatic step(input logic [15:0] p, input logic re, input logic [15:0] a,
                      input logic iss, input logic [15:0] ia, input logic exp_req,
                      input logic pf_push, input logic [15:0] pf_addr);
    orl_exp_t    e;
    logic [15:0] exp_head;
    logic        exp_v;
    logic [15:0] exp_o;
    @(negedge clk);
    reset            = 1'b0;
    bus.pc           = p;
    bus.dReadEnable  = re;
    bus.dAddress     = a;
    bus.memIssue     = iss;
    bus.memIssueAddr = ia;
    #1;
    chk1("memRequest", bus.memRequest, exp_req);
    exp_head = (pf_q.size() != 0) ? pf_q[0] : 16'h0000;
    chk16("requestAddress", bus.requestAddress, exp_head);
    if (exp_req && pf_q.size() != 0) void'(pf_q.pop_front());
    if (pf_push) pf_q.push_back(pf_addr);
    exp_v = 1'b0;
    exp_o = 16'hFFFF;
    if (orl_q.size() != 0 && orl_q[0].due == cyc) begin
      e     = orl_q.pop_front();
      exp_v = 1'b1;
      exp_o = e.addr;
    end
    chk1("orlValid", bus.orlValid, exp_v);
    chk16("orlOutput", bus.orlOutput, exp_o);
    if (iss) begin
      e.addr = ia;
      e.due  = cyc + 4;
      orl_q.push_back(e);
    end
    cyc++;
  endtask

  task automatic ld(input logic [15:0] p, input logic [15:0] a);
    step(p, 1'b1, a, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic ldp(input logic [15:0] p, input logic [15:0] a, input logic [15:0] pf);
    step(p, 1'b1, a, 1'b0, 16'h0, 1'b0, 1'b1, pf);
  endtask

  task automatic idle(input logic exp_req);
    step(16'h0, 1'b0, 16'h0, 1'b0, 16'h0, exp_req, 1'b0, 16'h0);
  endtask

  task automatic issue(input logic [15:0] ia, input logic exp_req);
    step(16'h0, 1'b0, 16'h0, 1'b1, ia, exp_req, 1'b0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset            = 1'b1;
      bus.pc           = 16'($urandom);
      bus.dReadEnable  = 1'($urandom);
      bus.dAddress     = 16'($urandom);
      bus.memIssue     = 1'($urandom);
      bus.memIssueAddr = 16'($urandom);
      #1;
      chk1("rst_memRequest", bus.memRequest, 1'b0);
      chk16("rst_requestAddress", bus.requestAddress, 16'h0000);
      chk1("rst_orlValid", bus.orlValid, 1'b0);
      chk16("rst_orlOutput", bus.orlOutput, 16'hFFFF);
    end
    pf_q.delete();
    orl_q.delete();
  endtask

  initial begin
    reset            = 1'b1;
    bus.pc           = '0;
    bus.dReadEnable  = 1'b0;
    bus.dAddress     = '0;
    bus.memIssue     = 1'b0;
    bus.memIssueAddr = '0;

    do_reset(2);
    idle(1'b0);

    // basic stride training
    ld(16'h0010, 16'h0100);
    ld(16'h0010, 16'h0104);
    ldp(16'h0010, 16'h0108, 16'h010C);
    idle(1'b1);
    idle(1'b0);

    // demand loads block the request; head stays put
    ld(16'h0050, 16'h0100);
    ld(16'h0050, 16'h0104);
    ldp(16'h0050, 16'h0108, 16'h010C);
    ld(16'h0041, 16'h3000);
    ld(16'h0042, 16'h3100);
    ld(16'h0043, 16'h3200);
    idle(1'b1);
    idle(1'b0);

    // ORL timing, single and back-to-back
    issue(16'h0200, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b0);
    issue(16'h0300, 1'b0);
    issue(16'h0304, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // aliasing reallocation
    ld(16'h0010, 16'h0400);
    ld(16'h0010, 16'h0410);
    ldp(16'h0010, 16'h0420, 16'h0430);
    idle(1'b1);
    ld(16'h0020, 16'h0440);
    ld(16'h0010, 16'h0430);
    idle(1'b0);
    ld(16'h0010, 16'h0440);
    idle(1'b0);

    // queue overflow
    ld(16'h0061, 16'h0800);
    ld(16'h0061, 16'h0804);
    ldp(16'h0061, 16'h0808, 16'h080C);
    ldp(16'h0061, 16'h080C, 16'h0810);
    ld(16'h0061, 16'h0810);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // ORL-stage and in-cycle issue filtering
    ld(16'h0072, 16'h0900);
    step(16'h0072, 1'b1, 16'h0908, 1'b1, 16'h0918, 1'b0, 1'b0, 16'h0);
    ld(16'h0072, 16'h0910);
    idle(1'b0);
    step(16'h0072, 1'b1, 16'h0918, 1'b1, 16'h0922, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // 16-bit wrap and negative stride
    ld(16'h0033, 16'hFFF4);
    ld(16'h0033, 16'hFFF8);
    ldp(16'h0033, 16'hFFFC, 16'h0000);
    idle(1'b1);
    idle(1'b0);
    ld(16'h0034, 16'h0500);
    ld(16'h0034, 16'h04F0);
    ldp(16'h0034, 16'h04E0, 16'h04D0);
    idle(1'b1);
    idle(1'b0);

    // mid-operation reset drops queue, ORL and RPT training
    ld(16'h0035, 16'h0600);
    ld(16'h0035, 16'h0604);
    step(16'h0035, 1'b1, 16'h0608, 1'b1, 16'h0700, 1'b0, 1'b1, 16'h060C);
    do_reset(1);
    idle(1'b0);
    ld(16'h0035, 16'h060C);
    for (int i = 0; i < 5; i++) idle(1'b0);

    chkint("pf_scoreboard_drained", pf_q.size(), 0);
    chkint("orl_scoreboard_drained", orl_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
